// File: rtl/fifo_fwft_unpacker_reader_pkg.sv
// fifo_fwft_unpacker_reader_pkg: shared types and helpers for the FWFT read-side unpacker
package fifo_fwft_unpacker_reader_pkg;
  localparam int MAX_LANES = 64;
  typedef enum logic {ST_FILL, ST_FLUSH} fill_state_e;
  function automatic int cnt_width(input int pack);
    return $clog2(pack) + 1;
  endfunction
  // lanes 0..cnt-1 set; cnt==MAX_LANES gives all ones
  function automatic logic [MAX_LANES-1:0] keep_from_cnt(input int unsigned cnt);
    return ~({MAX_LANES{1'b1}} << cnt);
  endfunction
endpackage

// File: rtl/stream_out_reg.sv
// stream_out_reg: valid/ready holding register carrying data, keep and last
module stream_out_reg #(
  parameter int W = 32,
  parameter int K = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] in_data,
  input  logic [K-1:0] in_keep,
  input  logic         in_last,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] data,
  output logic [K-1:0] keep,
  output logic         last
);
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
      keep  <= '0;
      last  <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= in_data;
      keep  <= in_keep;
      last  <= in_last;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end
endmodule

// File: rtl/fifo_fwft_unpacker_reader.sv
// fifo_fwft_unpacker_reader: pops FWFT FIFO entries and packs PACK lanes per output word
module fifo_fwft_unpacker_reader
  import fifo_fwft_unpacker_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PACK       = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       empty_i,
  input  logic [DATA_WIDTH-1:0]      rdata_i,
  output logic                       ren_o,
  input  logic                       flush_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [PACK*DATA_WIDTH-1:0] out_data_o,
  output logic [PACK-1:0]            out_keep_o,
  output logic                       out_last_o,
  output logic                       busy_o
);
  localparam int CNT_WIDTH = cnt_width(PACK);
  localparam int WW        = PACK * DATA_WIDTH;
  fill_state_e          state;
  logic [CNT_WIDTH-1:0] lane_cnt;
  logic [WW-1:0]        pack_q, pack_nx, ld_data;
  logic [PACK-1:0]      ld_keep;
  logic                 out_free, last_pop, flush_req, flush_ld, ld;
  assign out_free  = !out_valid_o | out_ready_i;
  assign ren_o     = !rst & !empty_i & !flush_i & (state == ST_FILL) &
                     ((lane_cnt < CNT_WIDTH'(PACK - 1)) | out_free);
  assign last_pop  = ren_o & (lane_cnt == CNT_WIDTH'(PACK - 1));
  // a flush only means something when lanes are partially filled
  assign flush_req = (flush_i | (state == ST_FLUSH)) & (lane_cnt != '0);
  assign flush_ld  = flush_req & out_free;
  assign ld        = last_pop | flush_ld;
  assign ld_keep   = last_pop ? '1 : PACK'(keep_from_cnt(int'(lane_cnt)));
  assign busy_o    = (lane_cnt != '0) | out_valid_o | (state == ST_FLUSH);
  always_comb begin
    pack_nx = pack_q;
    if (ren_o) pack_nx[int'(lane_cnt)*DATA_WIDTH +: DATA_WIDTH] = rdata_i;
  end
  // unused lanes of a flushed word are forced to zero
  always_comb begin
    ld_data = '0;
    for (int k = 0; k < PACK; k++)
      ld_data[k*DATA_WIDTH +: DATA_WIDTH] = ld_keep[k] ? pack_nx[k*DATA_WIDTH +: DATA_WIDTH] : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_FILL;
      lane_cnt <= '0;
      pack_q   <= '0;
    end else begin
      pack_q   <= pack_nx;
      lane_cnt <= ld ? '0 : lane_cnt + CNT_WIDTH'(ren_o);
      state    <= (flush_req & !out_free) ? ST_FLUSH : ST_FILL;
    end
  end
  stream_out_reg #(.W(WW), .K(PACK)) u_out (
    .clk    (clk),
    .rst    (rst),
    .load   (ld),
    .in_data(ld_data),
    .in_keep(ld_keep),
    .in_last(flush_ld),
    .ready  (out_ready_i),
    .valid  (out_valid_o),
    .data   (out_data_o),
    .keep   (out_keep_o),
    .last   (out_last_o)
  );
endmodule
